uart_tx: RTL and testbench

UART transmitter: the outgoing counterpart of the design's receiver. It serialises one parallel byte per request into a standard asynchronous frame: start bit (0), data LSB first, optional parity, stop bit(s) (1). It is paced by the same 16×-oversampling tick from the existing `baud` generator that drives the receiver, so both ends share one baud source at the top level.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_tx.sv | 164 ++++++++++++++++
 tb/tb_uart_tx.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module : uart_pkg
// Brief  : Shared UART definitions: FSM state encoding, oversampling ratio
//          and default frame constants used by both transmitter and receiver.
// Rev    : 1.0  initial release
// ============================================================================
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      STOP   = 3'd3,
      PARITY = 3'd4
   } uart_state_t;

   localparam int OVERSAMPLE      = 16;
   localparam int DBIT_DEFAULT    = 8;
   localparam int SB_TICK_DEFAULT = 16;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module : uart_tx
// Brief  : UART transmitter paced by a 16x oversampling tick. Define
//          UART_TX_PARITY_EN to insert one even-parity bit before the stop bits.
// Rev    : 1.0  initial release
// ============================================================================
module uart_tx
   import uart_pkg::*;
#(
   parameter int DBIT    = DBIT_DEFAULT,
   parameter int SB_TICK = SB_TICK_DEFAULT
)
(
   input  logic            clk,
   input  logic            reset,
   input  logic            baud,
   input  logic            tx_start,
   input  logic [DBIT-1:0] d_in,
   output logic            tx,
   output logic            tx_busy,
   output logic            tx_done
);

   localparam int c_tick_w = $clog2(max_int(OVERSAMPLE, SB_TICK));
   localparam int c_bit_w  = (DBIT > 1) ? $clog2(DBIT) : 1;

   localparam logic [c_tick_w-1:0] c_os_last   = c_tick_w'(OVERSAMPLE - 1);
   localparam logic [c_tick_w-1:0] c_stop_last = c_tick_w'(SB_TICK - 1);
   localparam logic [c_bit_w-1:0]  c_bit_last  = c_bit_w'(DBIT - 1);

   uart_state_t         r_state, w_state_next;
   logic [c_tick_w-1:0] r_tick,  w_tick_next;
   logic [c_bit_w-1:0]  r_bit,   w_bit_next;
   logic [DBIT-1:0]     r_shift, w_shift_next;
   logic                r_tx,    w_tx_next;
   logic                r_busy;
   logic                r_done,  w_done_next;

`ifdef UART_TX_PARITY_EN
   // Parity is taken from the byte at acceptance, since the shift register is consumed.
   logic r_parity;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_parity <= 1'b0;
      else if (r_state == IDLE && tx_start)
         r_parity <= ^d_in;
   end
`endif

   always_comb begin
      w_state_next = r_state;
      w_tick_next  = r_tick;
      w_bit_next   = r_bit;
      w_shift_next = r_shift;
      w_done_next  = 1'b0;

      case (r_state)
         IDLE: begin
            if (tx_start) begin
               w_state_next = START;
               w_tick_next  = '0;
               w_shift_next = d_in;
            end
         end
         START: begin
            if (baud) begin
               if (r_tick == c_os_last) begin
                  w_tick_next  = '0;
                  w_bit_next   = '0;
                  w_state_next = DATA;
               end else begin
                  w_tick_next = r_tick + 1'b1;
               end
            end
         end
         DATA: begin
            if (baud) begin
               if (r_tick == c_os_last) begin
                  w_tick_next  = '0;
                  w_shift_next = r_shift >> 1;
                  if (r_bit == c_bit_last) begin
`ifdef UART_TX_PARITY_EN
                     w_state_next = PARITY;
`else
                     w_state_next = STOP;
`endif
                  end else begin
                     w_bit_next = r_bit + 1'b1;
                  end
               end else begin
                  w_tick_next = r_tick + 1'b1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (baud) begin
               if (r_tick == c_os_last) begin
                  w_tick_next  = '0;
                  w_state_next = STOP;
               end else begin
                  w_tick_next = r_tick + 1'b1;
               end
            end
         end
`endif
         STOP: begin
            if (baud) begin
               if (r_tick == c_stop_last) begin
                  w_tick_next  = '0;
                  w_state_next = IDLE;
                  w_done_next  = 1'b1;
               end else begin
                  w_tick_next = r_tick + 1'b1;
               end
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // Line level follows the state being entered so tx changes on the same edge as state.
   always_comb begin
      w_tx_next = 1'b1;
      case (w_state_next)
         START:   w_tx_next = 1'b0;
         DATA:    w_tx_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  w_tx_next = r_parity;
`endif
         default: w_tx_next = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_tick  <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_tx    <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_tick  <= w_tick_next;
         r_bit   <= w_bit_next;
         r_shift <= w_shift_next;
         r_tx    <= w_tx_next;
         r_busy  <= (w_state_next != IDLE);
         r_done  <= w_done_next;
      end
   end

   assign tx      = r_tx;
   assign tx_busy = r_busy;
   assign tx_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_tx
// Brief  : Self-checking bench for uart_tx: table of frames plus hand-written
//          reset, ignored-request and back-to-back sequences.
// Rev    : 1.0  initial release
// ============================================================================
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
   localparam int PAR_EN      = 1;
   localparam int FRAME_TICKS = 176;
`else
   localparam int PAR_EN      = 0;
   localparam int FRAME_TICKS = 160;
`endif

   logic       clk      = 1'b0;
   logic       reset    = 1'b1;
   logic       baud     = 1'b0;
   logic       tx_start = 1'b0;
   logic [7:0] d_in     = 8'h00;
   logic       tx;
   logic       tx_busy;
   logic       tx_done;

   int checks = 0;
   int errors = 0;
   int period = 1;
   int bcnt   = 0;

   logic [7:0] got;
   int         done_c;
   int         bad;

   typedef struct {
      logic [7:0] data;
      logic       par;
      int         per;
   } vec_t;

   vec_t vecs [6];

   uart_tx #(.DBIT(8), .SB_TICK(16)) dut (
      .clk      (clk),
      .reset    (reset),
      .baud     (baud),
      .tx_start (tx_start),
      .d_in     (d_in),
      .tx       (tx),
      .tx_busy  (tx_busy),
      .tx_done  (tx_done)
   );

   always #5 clk = ~clk;

   // One-cycle baud pulse every `period` clocks (period 1 = tick every cycle).
   always @(posedge clk) begin
      #1;
      if (bcnt >= period - 1) begin
         bcnt = 0;
         baud = 1'b1;
      end else begin
         bcnt = bcnt + 1;
         baud = 1'b0;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic exp_bit(input logic [7:0] d, input logic p, input int t);
      int k;
      k = t / 16;
      if (k == 0) return 1'b0;
      if (k <= 8) return d[k-1];
      if (PAR_EN == 1 && k == 9) return p;
      return 1'b1;
   endfunction

   task automatic send(input logic [7:0] d);
      @(posedge clk); #2;
      d_in     = d;
      tx_start = 1'b1;
      @(posedge clk); #2;
      tx_start = 1'b0;
      d_in     = ~d;
   endtask

   // Called just after the accepting edge; returns at the negedge of the tx_done cycle.
   task automatic capture(input string tag, input logic [7:0] data, input logic par,
                          output logic [7:0] byte_out, output int done_cyc);
      int  tk;
      int  mism;
      int  busy_bad;
      int  limit;
      bit  seen;
      tk = 0; mism = 0; busy_bad = 0; seen = 0; done_cyc = 0;
      byte_out = 8'h00;
      limit = (FRAME_TICKS + 2) * period + 20;
      for (int c = 1; c <= limit && !seen; c++) begin
         @(negedge clk);
         if (c == 1) chk({tag, "_first_cycle"}, {30'd0, tx, tx_busy}, 32'd1);
         if (tx_done) begin
            seen     = 1;
            done_cyc = c;
            chk({tag, "_done_tick"}, tk, FRAME_TICKS);
            chk({tag, "_busy_at_done"}, {31'd0, tx_busy}, 32'd0);
         end else if (tk < FRAME_TICKS) begin
            if (tx !== exp_bit(data, par, tk)) mism++;
            if (tx_busy !== 1'b1) busy_bad++;
            if (tk >= 16 && tk < 144 && (tk % 16) == 8) byte_out[tk/16 - 1] = tx;
         end
         if (!seen) begin
            @(posedge clk);
            if (baud) tk++;
         end
      end
      chk({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
      chk({tag, "_frame_bits"}, mism, 0);
      chk({tag, "_busy_frame"}, busy_bad, 0);
      chk({tag, "_byte"}, {24'd0, byte_out}, {24'd0, data});
   endtask

   initial begin
      vecs = '{
         '{8'h55, 1'b0, 1},
         '{8'hA3, 1'b0, 7},
         '{8'h00, 1'b0, 1},
         '{8'hFF, 1'b0, 3},
         '{8'h07, 1'b1, 1},
         '{8'h03, 1'b0, 2}
      };

      period = 1;
      repeat (3) @(posedge clk);
      #2;
      chk("reset_tx", {31'd0, tx}, 32'd1);
      chk("reset_busy", {31'd0, tx_busy}, 32'd0);
      chk("reset_done", {31'd0, tx_done}, 32'd0);
      reset = 1'b0;

      for (int i = 0; i < 6; i++) begin
         period = vecs[i].per;
         repeat (4) @(posedge clk);
         send(vecs[i].data);
         capture($sformatf("vec%0d", i), vecs[i].data, vecs[i].par, got, done_c);
         if (vecs[i].per == 1) chk($sformatf("vec%0d_done_cycle", i), done_c, FRAME_TICKS + 1);
         @(negedge clk);
         chk($sformatf("vec%0d_done_pulse", i), {31'd0, tx_done}, 32'd0);
      end

      // Request during a frame must be ignored.
      period = 1;
      repeat (4) @(posedge clk);
      send(8'h0F);
      fork
         capture("ignore", 8'h0F, 1'b0, got, done_c);
         begin
            repeat (50) @(posedge clk);
            #2;
            d_in     = 8'hFF;
            tx_start = 1'b1;
            @(posedge clk); #2;
            tx_start = 1'b0;
         end
      join
      bad = 0;
      repeat (200) begin
         @(negedge clk);
         if (tx_done || !tx || tx_busy) bad++;
      end
      chk("ignore_no_second_frame", bad, 0);

      // tx_start held high: next frame accepted in the tx_done cycle.
      @(posedge clk); #2;
      d_in     = 8'h12;
      tx_start = 1'b1;
      @(posedge clk); #2;
      capture("b2b_first", 8'h12, 1'b0, got, done_c);
      d_in = 8'h34;
      @(posedge clk); #2;
      tx_start = 1'b0;
      d_in     = 8'hFF;
      capture("b2b_second", 8'h34, 1'b1, got, done_c);
      @(negedge clk);
      chk("b2b_done_pulse", {31'd0, tx_done}, 32'd0);

      // Asynchronous reset in mid-frame aborts without tx_done.
      repeat (4) @(posedge clk);
      send(8'hC6);
      repeat (40) @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("midreset_tx", {31'd0, tx}, 32'd1);
      chk("midreset_busy", {31'd0, tx_busy}, 32'd0);
      @(posedge clk); #2;
      reset = 1'b0;
      bad = 0;
      repeat (200) begin
         @(negedge clk);
         if (tx_done || !tx || tx_busy) bad++;
      end
      chk("midreset_quiet", bad, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
